regfile_wb_arbiter: RTL

//  Shares the single write port of the 32x32 register bank between NREQ write-back requesters.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/regfile_wb_arbiter.sv | 79 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-bank constants and the write-back request record.
package regfile_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_W-1:0]      data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the scan at rr_ptr, which
// advances past the winner on every grant.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_idx;
  int            w_j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_idx   = '0;
    w_j     = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(r_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      w_idx = IW'(w_j);
      if (en && (gnt == '0) && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        gnt_idx    = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_ptr <= '0;
    else if (|gnt)
      r_ptr <= (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register bank's single write port among NREQ write-back sources:
// drops x0 writes, arbitrates the rest round-robin, registers the winner.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter  int NREQ   = 2,
  parameter  int DATA_W = REG_W,
  parameter  int ADDR_W = REG_ADDR_W,
  localparam int GW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hold,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        write_register,
  output logic [DATA_W-1:0]        write_data,
  output logic [GW-1:0]            grant_id
);

  logic [NREQ-1:0][ADDR_W-1:0] w_addr;
  logic [NREQ-1:0][DATA_W-1:0] w_data;
  logic [NREQ-1:0]             w_zero;
  logic [NREQ-1:0]             w_nz;
  logic [NREQ-1:0]             w_gnt;
  logic [GW-1:0]               w_gidx;
  logic                        w_en;

  logic                        r_we;
  logic [ADDR_W-1:0]           r_waddr;
  logic [DATA_W-1:0]           r_wdata;
  logic [GW-1:0]               r_gid;

  // x0 writes are acked immediately and never compete for the port
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign w_addr[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign w_data[i] = req_data[i*DATA_W +: DATA_W];
    assign w_zero[i] = req_valid[i] & (w_addr[i] == ADDR_W'(ZERO_REG));
    assign w_nz[i]   = req_valid[i] & ~w_zero[i];
  end

  assign w_en = rst & ~hold;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_nz),
    .en      (w_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gidx)
  );

  assign req_ready = rst ? (w_zero | w_gnt) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_gid   <= '0;
    end else begin
      r_we <= |w_gnt;
      if (|w_gnt) begin
        r_waddr <= w_addr[w_gidx];
        r_wdata <= w_data[w_gidx];
        r_gid   <= w_gidx;
      end
    end
  end

  assign RegWrite       = r_we;
  assign write_register = r_waddr;
  assign write_data     = r_wdata;
  assign grant_id       = r_gid;

endmodule
